// File: rtl/led_blink_pwm.sv
// Multi-channel LED driver: OFF / ON / BLINK / PWM per channel, run-time reconfigurable.
// Define LED_BLINK_PWM_BREATHE_EN to add mode 4 (BREATHE, triangular duty ramp).

module led_blink_pwm_ch #(
    parameter int         CNT_W        = 24,
    parameter int         PWM_W        = 8,
    parameter int         DEFAULT_HALF = 8000000,
    parameter logic [2:0] RST_MODE     = 3'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [2:0]       mode_w,
    input  logic [CNT_W-1:0] val,
    input  logic [PWM_W-1:0] pwm_cnt,
    output logic             led,
    output logic             pulse
);
    localparam logic [2:0] MODE_OFF     = 3'd0;
    localparam logic [2:0] MODE_ON      = 3'd1;
    localparam logic [2:0] MODE_BLINK   = 3'd2;
    localparam logic [2:0] MODE_PWM     = 3'd3;
`ifdef LED_BLINK_PWM_BREATHE_EN
    localparam logic [2:0] MODE_BREATHE = 3'd4;
    localparam logic [PWM_W-1:0] PWM_MAX = '1;
    logic dir_up;
`endif

    logic [2:0]       mode;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] cnt;
    logic [PWM_W-1:0] duty;
    logic             blink;

    always_ff @(posedge clk) begin
        if (rst) begin
            mode  <= RST_MODE;
            half  <= CNT_W'(DEFAULT_HALF);
            cnt   <= '0;
            duty  <= '0;
            blink <= 1'b0;
            led   <= 1'b0;
            pulse <= 1'b0;
`ifdef LED_BLINK_PWM_BREATHE_EN
            dir_up <= 1'b1;
`endif
        end else if (we) begin
            // A write restarts the channel; led holds until the new mode takes over next edge.
            mode  <= mode_w;
            cnt   <= '0;
            blink <= 1'b0;
            pulse <= 1'b0;
            case (mode_w)
                MODE_BLINK: half <= val;
                MODE_PWM:   duty <= val[PWM_W-1:0];
`ifdef LED_BLINK_PWM_BREATHE_EN
                MODE_BREATHE: begin
                    half   <= val;
                    duty   <= '0;
                    dir_up <= 1'b1;
                end
`endif
                default: ;
            endcase
        end else begin
            pulse <= 1'b0;
            case (mode)
                MODE_OFF: led <= 1'b0;
                MODE_ON:  led <= 1'b1;
                MODE_BLINK: begin
                    if (cnt == half) begin
                        cnt   <= '0;
                        blink <= ~blink;
                        led   <= ~blink;
                        pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                        led <= blink;
                    end
                end
                MODE_PWM: led <= (pwm_cnt < duty);
`ifdef LED_BLINK_PWM_BREATHE_EN
                MODE_BREATHE: begin
                    led <= (pwm_cnt < duty);
                    if (cnt == half) begin
                        cnt   <= '0;
                        pulse <= 1'b1;
                        // Flip on reaching an endpoint so each endpoint lasts one step.
                        if (dir_up) begin
                            duty <= duty + 1'b1;
                            if (duty == PWM_MAX - 1'b1) dir_up <= 1'b0;
                        end else begin
                            duty <= duty - 1'b1;
                            if (duty == {{(PWM_W-1){1'b0}}, 1'b1}) dir_up <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                default: led <= 1'b0;
            endcase
        end
    end
endmodule

module led_blink_pwm #(
    parameter int NUM_CH       = 3,
    parameter int CNT_W        = 24,
    parameter int PWM_W        = 8,
    parameter int DEFAULT_HALF = 8000000,
    parameter int CH_W         = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [2:0]        cfg_mode,
    input  logic [CNT_W-1:0]  cfg_val,
    output logic [NUM_CH-1:0] led_out,
    output logic [NUM_CH-1:0] toggle_pulse
);
    logic [PWM_W-1:0]  pwm_cnt;
    logic [NUM_CH-1:0] ch_we;

    always_ff @(posedge clk) begin
        if (rst) pwm_cnt <= '0;
        else     pwm_cnt <= pwm_cnt + 1'b1;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Out-of-range channel indices match no instance, so such writes are dropped.
        assign ch_we[i] = cfg_we && (32'(cfg_ch) == 32'(i));

        led_blink_pwm_ch #(
            .CNT_W        (CNT_W),
            .PWM_W        (PWM_W),
            .DEFAULT_HALF (DEFAULT_HALF),
            .RST_MODE     ((i == 0) ? 3'd2 : 3'd0)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .we      (ch_we[i]),
            .mode_w  (cfg_mode),
            .val     (cfg_val),
            .pwm_cnt (pwm_cnt),
            .led     (led_out[i]),
            .pulse   (toggle_pulse[i])
        );
    end
endmodule

// File: tb/tb_led_blink_pwm.sv
// Directed bench for led_blink_pwm; expectations queued per edge and checked 1ns after it.
module tb_led_blink_pwm;
    localparam int NUM_CH = 3, CNT_W = 24, PWM_W = 8, DEFAULT_HALF = 4, CH_W = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_we = 1'b0;
    logic [CH_W-1:0]   cfg_ch = '0;
    logic [2:0]        cfg_mode = '0;
    logic [CNT_W-1:0]  cfg_val = '0;
    logic [NUM_CH-1:0] led_out, toggle_pulse;

    int checks = 0, errors = 0, j = 0;
    logic [5:0] sbq[$];

    always #5 clk = ~clk;

    led_blink_pwm #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PWM_W(PWM_W),
        .DEFAULT_HALF(DEFAULT_HALF), .CH_W(CH_W)
    ) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_val(cfg_val),
        .led_out(led_out), .toggle_pulse(toggle_pulse)
    );

    task automatic chk3(input string tag, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, act, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int act, input int exp);
        checks++;
        assert (act == exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, act, exp);
        end
    endtask

    // Queue the expected outputs for the next edge, advance, then pop and compare.
    task automatic tick(input string tag, input logic [2:0] el, input logic [2:0] ep);
        logic [5:0] e;
        sbq.push_back({el, ep});
        @(posedge clk);
        #1;
        j++;
        cfg_we = 1'b0;
        e = sbq.pop_front();
        chk3({tag, " led"}, led_out, e[5:3]);
        chk3({tag, " pulse"}, toggle_pulse, e[2:0]);
    endtask

    task automatic wr(input int ch, input int mode, input int val);
        cfg_we   = 1'b1;
        cfg_ch   = CH_W'(ch);
        cfg_mode = 3'(mode);
        cfg_val  = CNT_W'(val);
    endtask

    // Channel 0 default blink, k = edges since reset release (half=4, period 10).
    function automatic logic bl(input int k); return ((k / 5) % 2) == 1; endfunction
    function automatic logic bp(input int k); return (k % 5) == 0; endfunction
    // PWM comparator output at edge k: free-running counter holds (k-1) mod 256 before it.
    function automatic logic pw(input int k, input int duty); return ((k - 1) % 256) < duty; endfunction
    function automatic int tri_duty(input int s);
        int m;
        m = s % 510;
        return (m <= 255) ? m : 510 - m;
    endfunction

    initial begin
        int n, hi;

        tick("reset", 3'b000, 3'b000);
        tick("reset", 3'b000, 3'b000);
        rst = 1'b0;
        j = 0;

        for (int k = 0; k < 40; k++) begin
            n = j + 1;
            tick("blink_default", {2'b00, bl(n)}, {2'b00, bp(n)});
        end

        wr(1, 1, 0);
        n = j + 1;
        tick("wr_on", {2'b00, bl(n)}, {2'b00, bp(n)});
        wr(2, 3, 64);
        n = j + 1;
        tick("wr_pwm", {1'b0, 1'b1, bl(n)}, {2'b00, bp(n)});
        hi = 0;
        for (int k = 0; k < 512; k++) begin
            n = j + 1;
            tick("pwm64", {pw(n, 64), 1'b1, bl(n)}, {2'b00, bp(n)});
            if (n <= 298) hi += int'(led_out[2]);
        end
        chk_int("pwm64_high_count", hi, 64);

        // Half-period 0: ch0 flips every edge after the write edge (j=555).
        wr(0, 2, 0);
        n = j + 1;
        tick("wr_fast", {pw(n, 64), 1'b1, bl(n - 1)}, 3'b000);
        for (int k = 0; k < 10; k++) begin
            n = j + 1;
            tick("fast_blink", {pw(n, 64), 1'b1, ((n - 555) % 2) == 1}, 3'b001);
        end

        wr(3, 1, 0);
        for (int k = 0; k < 9; k++) begin
            n = j + 1;
            tick("bad_ch", {pw(n, 64), 1'b1, ((n - 555) % 2) == 1}, 3'b001);
        end

        wr(0, 2, 4);
        n = j + 1;
        tick("wr_blink4", {pw(n, 64), 1'b1, ((n - 1 - 555) % 2) == 1}, 3'b000);
        for (int k = 0; k < 3; k++) begin
            n = j + 1;
            tick("blink4_cnt", {pw(n, 64), 1'b1, 1'b0}, 3'b000);
        end
        rst = 1'b1;
        tick("rst_mid", 3'b000, 3'b000);
        rst = 1'b0;
        j = 0;
        for (int k = 0; k < 12; k++) begin
            n = j + 1;
            tick("restart", {2'b00, bl(n)}, {2'b00, bp(n)});
        end

        wr(1, 4, 0);
        n = j + 1;
        tick("wr_breathe", {2'b00, bl(n)}, {2'b00, bp(n)});
`ifdef LED_BLINK_PWM_BREATHE_EN
        for (int k = 0; k < 520; k++) begin
            n = j + 1;
            tick("breathe", {1'b0, pw(n, tri_duty(n - 14)), bl(n)}, {1'b0, 1'b1, bp(n)});
        end
`else
        for (int k = 0; k < 20; k++) begin
            n = j + 1;
            tick("breathe_off", {2'b00, bl(n)}, {2'b00, bp(n)});
        end
`endif

        chk_int("scoreboard_drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
